// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined core: widths, ALU opcodes and
// the ID/EX control bundle.
package cpu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RADDR_W = 3;
  localparam int unsigned ALU_W   = 4;

  typedef enum logic [ALU_W-1:0] {
    ALU_NOP   = 4'b0000,
    ALU_LOAD  = 4'b0010,
    ALU_STORE = 4'b0011,
    ALU_JUMP  = 4'b0100,
    ALU_EQ    = 4'b0101,
    ALU_SHR   = 4'b0110,
    ALU_SHL   = 4'b0111,
    ALU_ADD   = 4'b1000,
    ALU_SUB   = 4'b1001,
    ALU_MUL   = 4'b1010,
    ALU_DIV   = 4'b1011,
    ALU_AND   = 4'b1100,
    ALU_OR    = 4'b1101,
    ALU_NOT   = 4'b1110,
    ALU_XOR   = 4'b1111
  } alu_op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ex_ctrl_t;

  // A producer supplies register rs when it writes a nonzero matching index.
  function automatic logic fwd_hit(input logic we,
                                   input logic [RADDR_W-1:0] rd,
                                   input logic [RADDR_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/operand_fwd.sv
// Execute-side forwarding mux for one operand: EX/MEM beats MEM/WB beats
// the stored value; R0 always reads as zero.
module operand_fwd
  import cpu_pkg::*;
(
  input  logic [RADDR_W-1:0] rs,
  input  logic [DATA_W-1:0]  stored,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]  exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]  memwb_result,
  output logic [DATA_W-1:0]  value_c
);

  always_comb begin
    value_c = stored;
    if (rs == '0) begin
      value_c = '0;
    end else if (fwd_hit(exmem_reg_write, exmem_rd, rs)) begin
      value_c = exmem_result;
    end else if (fwd_hit(memwb_reg_write, memwb_rd, rs)) begin
      value_c = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands and control, forwards
// from EX/MEM and MEM/WB, and inserts a bubble on load-use hazards.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [ALU_W-1:0]   id_alu_ctrl,
  input  logic [RADDR_W-1:0] id_rs1,
  input  logic [RADDR_W-1:0] id_rs2,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0]  id_rs1_data,
  input  logic [DATA_W-1:0]  id_rs2_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_use_imm,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               stall_in,
  input  logic               flush,
  input  logic               exmem_reg_write,
  input  logic [RADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0]  exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0]  memwb_result,
  output logic               hazard_stall,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  src_a,
  output logic [DATA_W-1:0]  src_b,
  output logic [ALU_W-1:0]   alu_ctrl,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic [DATA_W-1:0]  ex_store_data
);

  logic               valid_q;
  ex_ctrl_t           ctrl_q;
  logic [ALU_W-1:0]   alu_q;
  logic [RADDR_W-1:0] rd_q;
  logic [RADDR_W-1:0] rs1_q;
  logic [RADDR_W-1:0] rs2_q;
  logic [DATA_W-1:0]  rs1_data_q;
  logic [DATA_W-1:0]  rs2_data_q;
  logic [DATA_W-1:0]  imm_q;
  logic               use_imm_q;

  logic [DATA_W-1:0]  fwd_a_c;
  logic [DATA_W-1:0]  fwd_b_c;
  logic               load_use_c;
  logic [DATA_W-1:0]  byp_rs1_c;
  logic [DATA_W-1:0]  byp_rs2_c;

  operand_fwd u_fwd_rs1 (
    .rs              (rs1_q),
    .stored          (rs1_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .value_c         (fwd_a_c)
  );

  operand_fwd u_fwd_rs2 (
    .rs              (rs2_q),
    .stored          (rs2_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .value_c         (fwd_b_c)
  );

  // A load in EX whose destination the decoding instruction reads.
  always_comb begin
    load_use_c = valid_q && ctrl_q.mem_read && (rd_q != '0) && id_valid &&
                 ((id_uses_rs1 && (id_rs1 == rd_q)) ||
                  (id_uses_rs2 && (id_rs2 == rd_q)));
    hazard_stall = load_use_c && !flush && !stall_in;
  end

  // Same-cycle write-back bypass for the register-file read.
  always_comb begin
    byp_rs1_c = id_rs1_data;
    byp_rs2_c = id_rs2_data;
    if (fwd_hit(memwb_reg_write, memwb_rd, id_rs1)) byp_rs1_c = memwb_result;
    if (fwd_hit(memwb_reg_write, memwb_rd, id_rs2)) byp_rs2_c = memwb_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      alu_q      <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      use_imm_q  <= 1'b0;
    end else if (flush || hazard_stall) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else if (stall_in) begin
      // Capture forwarded values so a producer retiring mid-stall is kept.
      rs1_data_q <= fwd_a_c;
      rs2_data_q <= fwd_b_c;
    end else begin
      valid_q          <= id_valid;
      ctrl_q.reg_write <= id_valid && id_reg_write;
      ctrl_q.mem_read  <= id_valid && id_mem_read;
      ctrl_q.mem_write <= id_valid && id_mem_write;
      alu_q            <= id_valid ? id_alu_ctrl : ALU_W'(0);
      rd_q             <= id_rd;
      rs1_q            <= id_rs1;
      rs2_q            <= id_rs2;
      rs1_data_q       <= byp_rs1_c;
      rs2_data_q       <= byp_rs2_c;
      imm_q            <= id_imm;
      use_imm_q        <= id_use_imm;
    end
  end

  assign ex_valid      = valid_q;
  assign alu_ctrl      = alu_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign src_a         = fwd_a_c;
  assign src_b         = use_imm_q ? imm_q : fwd_b_c;
  assign ex_store_data = fwd_b_c;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register of the 8-bit pipelined core, sitting directly upstream of the ALU. It latches decoded operands and control each cycle and resolves data hazards. Forwarding comes from the EX/MEM and MEM/WB stages; a load-use hazard inserts a one-cycle bubble. It drives the ALU's `SrcA`, `SrcB` and `ALUControl` inputs, and passes the memory and writeback control fields downstream.

## Interface
Parameters:
- DATA_W, 8, datapath width
- RADDR_W, 3, register index width (8 registers; R0 reads as zero and is never written)

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode holds a real instruction
- id_alu_ctrl  in  4  ALU opcode
- id_rs1, id_rs2, id_rd  in  RADDR_W  source and destination indices
- id_rs1_data, id_rs2_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  immediate
- id_use_imm  in  1  SrcB takes the immediate instead of rs2
- id_uses_rs1, id_uses_rs2  in  1  operand actually read; gates hazard checks
- id_reg_write, id_mem_read, id_mem_write  in  1  downstream control
- stall_in  in  1  downstream busy; hold stage contents
- flush  in  1  taken jump or branch; kill the incoming instruction
- exmem_reg_write  in  1, exmem_rd  in  RADDR_W, exmem_result  in  DATA_W  EX/MEM forwarding source
- memwb_reg_write  in  1, memwb_rd  in  RADDR_W, memwb_result  in  DATA_W  MEM/WB forwarding source
- hazard_stall  out  1  combinational; freezes PC and IF/ID
- ex_valid  out  1  stage holds a real instruction
- src_a, src_b  out  DATA_W  ALU operands after forwarding
- alu_ctrl  out  4  ALU opcode
- ex_rd  out  RADDR_W; ex_reg_write, ex_mem_read, ex_mem_write  out  1
- ex_store_data  out  DATA_W  forwarded rs2 value, used for STORE

## Operation
- **Load-use hazard:** hazard_stall = ex_valid & ex_mem_read & ex_rd≠0 & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). It is forced to 0 when flush or stall_in is high.
- **Update priority per edge:** reset > flush > stall_in > hazard_stall > load.
  - reset and flush: ex_valid←0, and all control bits ←0.
  - stall_in: hold every field except the operand refresh below.
  - hazard_stall: insert a bubble (ex_valid←0, control ←0).
  - load: capture the id_* fields.
- **Decode-side bypass on load:** if memwb_reg_write & memwb_rd≠0 & memwb_rd==id_rsN, capture memwb_result instead of id_rsN_data. This covers the write-back that happens in the same cycle as the register-file read.
- **Execute-side forwarding (combinational, per operand):**
  - First choice: EX/MEM when exmem_reg_write & exmem_rd≠0 & exmem_rd==rsN.
  - Otherwise MEM/WB, under the same conditions.
  - Otherwise the stored value.
  - Index 0 always yields 0.
- **Operand selection:** src_b = use_imm ? stored imm : forwarded rs2. ex_store_data is always the forwarded rs2.
- **Operand refresh under stall_in:** the stored rs1 and rs2 values are overwritten with their forwarded values each stalled cycle. A producer that retires during the stall is therefore not lost.
- **Invalid stage:** when ex_valid=0, alu_ctrl=4'b0000, so the ALU outputs 0. ex_reg_write, ex_mem_read and ex_mem_write are 0.

## Timing
- Latency is one cycle from id_* to ex_*. Throughput is one instruction per cycle when there is no hazard.
- Reset values: ex_valid, ex_rd, alu_ctrl, control bits and stored data are all 0. Therefore src_a=src_b=ex_store_data=0, and hazard_stall=0.
- A load-use hazard costs exactly one bubble cycle. On the following cycle the load is in MEM/WB and the dependent operand forwards from there.
- Simultaneous flush and hazard_stall: the flush wins and no stall is asserted.
- Reset asserted mid-stall: the stage is cleared on that edge.
- src_a, src_b and ex_store_data depend combinationally on the exmem_* and memwb_* inputs. There is no extra cycle.

## Structure
- The shared package cpu_pkg holds:
  - DATA_W and RADDR_W.
  - ALU opcode constants: ADD 1000, SUB 1001, MUL 1010, DIV 1011, AND 1100, OR 1101, NOT 1110, XOR 1111, SHR 0110, SHL 0111, LOAD 0010, STORE 0011, JUMP 0100, EQ 0101, NOP 0000.
  - A struct type for the ID/EX control bundle.
- Sub-module operand_fwd: one combinational forwarding selector, instantiated twice (rs1 and rs2).

## Test plan
- **Back-to-back ALU dependency:** ADD r1 (result 8'h05 in EX/MEM) followed by ADD r2 = r1+r1 → src_a=src_b=8'h05 in the same cycle.
- **Both forwarding paths match rs1:** EX/MEM=8'h11, MEM/WB=8'h22 → src_a=8'h11.
- **Load-use:** LOAD r3 then AND r4,r3,r2 → hazard_stall=1 for one cycle, ex_valid=0 for one cycle, then src_a=MEM/WB load data (e.g. 8'hA5).
- **Flush concurrent with a hazard:** flush=1 → hazard_stall=0, and on the next cycle ex_valid=0 and ex_reg_write=0.
- **Stall_in held 3 cycles:** while MEM/WB writes r1=8'h3C and then leaves, src_a stays 8'h3C after stall_in drops.
- **R0 and immediate:** an instruction with rs1=0, with EX/MEM writing rd=0 with 8'hFF → src_a=0. With id_use_imm=1 and imm=8'h07 → src_b=8'h07, and ex_store_data=forwarded rs2.
